// File: rtl/maxnet_batch_feeder.sv
// Packs four streamed IEEE-754 words into the MaxNet core operands, pulses start, then waits for done or a timeout.
// Latency: 2 edges best case from the 4th accept to res_valid. in_ready stays low from the 4th accept until the result is taken.
module maxnet_batch_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          SANITIZE       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] core_x1,
  output logic [31:0] core_x2,
  output logic [31:0] core_x3,
  output logic [31:0] core_x4,
  output logic        core_start,
  input  logic [31:0] core_out,
  input  logic        core_done,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_timeout,
  output logic        res_sanitized,
  output logic        busy
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_HOLD} state_t;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic          flag_q;
  logic [31:0]   x_q [4];
  logic          in_ready_q, start_q, res_valid_q, res_timeout_q, res_san_q, busy_q;
  logic [31:0]   res_data_q;

  logic        bad_w, flag_set_d, accept;
  logic [31:0] word_d;

  // -0.0 is a harmless clamp, so it is zeroed without marking the batch.
  always_comb begin
    bad_w      = in_data[31] | (in_data[30:23] == 8'hFF);
    word_d     = (SANITIZE && bad_w) ? 32'h0 : in_data;
    flag_set_d = SANITIZE && bad_w && (in_data != 32'h8000_0000);
    accept     = in_valid & in_ready_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_LOAD;
      cnt_q         <= 2'd0;
      timer_q       <= '0;
      flag_q        <= 1'b0;
      x_q[0]        <= 32'h0;
      x_q[1]        <= 32'h0;
      x_q[2]        <= 32'h0;
      x_q[3]        <= 32'h0;
      in_ready_q    <= 1'b0;
      start_q       <= 1'b0;
      res_data_q    <= 32'h0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_san_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            x_q[cnt_q] <= word_d;
            cnt_q      <= cnt_q + 2'd1;
            if (flag_set_d) flag_q <= 1'b1;
            if (cnt_q == 2'd3) begin
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_START;
            end
          end
        end
        S_START: begin
          start_q <= 1'b0;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the final timer cycle still wins.
          if (core_done) begin
            res_data_q    <= core_out;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            res_san_q     <= flag_q;
            state_q       <= S_HOLD;
          end else if (timer_q == TIMER_LAST) begin
            res_data_q    <= 32'h0;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_san_q     <= flag_q;
            state_q       <= S_HOLD;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_san_q     <= 1'b0;
            flag_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign core_x1       = x_q[0];
  assign core_x2       = x_q[1];
  assign core_x3       = x_q[2];
  assign core_x4       = x_q[3];
  assign core_start    = start_q;
  assign res_data      = res_data_q;
  assign res_valid     = res_valid_q;
  assign res_timeout   = res_timeout_q;
  assign res_sanitized = res_san_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_maxnet_batch_feeder.sv
// Directed bench for maxnet_batch_feeder with a short watchdog and sanitizing enabled.
module tb_maxnet_batch_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] core_x1, core_x2, core_x3, core_x4;
  logic        core_start;
  logic [31:0] core_out = 32'h0;
  logic        core_done = 1'b0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_timeout, res_sanitized, busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  maxnet_batch_feeder #(.TIMEOUT_CYCLES(16), .SANITIZE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_x1(core_x1), .core_x2(core_x2), .core_x3(core_x3), .core_x4(core_x4),
    .core_start(core_start), .core_out(core_out), .core_done(core_done),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_timeout(res_timeout), .res_sanitized(res_sanitized), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && core_start) starts++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) cyc();
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin cyc(); n++; end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_ready_wait got in_ready=%b exp 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, b, c, d);
    send(a, 0); send(b, 0); send(c, 0); send(d, 0);
  endtask

  task automatic pulse_done(input logic [31:0] v);
    core_out  = v;
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({in_ready, core_start, res_valid, res_timeout, res_sanitized, busy} !== 6'b0 ||
        core_x1 !== 32'h0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b x1=%h rd=%h rv=%b exp all 0", in_ready, core_x1, res_data, res_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge got %b exp 0", in_ready); end
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] got [4];
    logic [31:0] exp [4];
    int s0;
    exp = '{32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD};
    s0 = starts;
    send4(exp[0], exp[1], exp[2], exp[3]);
    checks++;
    if (core_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got start=%b rdy=%b busy=%b exp 1 0 1", core_start, in_ready, busy);
    end
    got = '{core_x1, core_x2, core_x3, core_x4};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_x%0d got %h exp %h", i + 1, got[i], exp[i]); end
    end
    cyc();
    checks++;
    if (core_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse got %b exp 0", core_start); end
    repeat (4) cyc();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", res_valid); end
    pulse_done(32'h3F4CCCCD);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h3F4CCCCD || res_timeout !== 1'b0 || res_sanitized !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%b d=%h to=%b san=%b exp 1 3f4ccccd 0 0", res_valid, res_data, res_timeout, res_sanitized);
    end
    checks++;
    if (starts - s0 !== 1) begin errors++; $display("FAIL basic_start_count got %0d exp 1", starts - s0); end
    take_result();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || res_data !== 32'h3F4CCCCD) begin
      errors++;
      $display("FAIL basic_release got v=%b rdy=%b busy=%b d=%h exp 0 1 0 3f4ccccd", res_valid, in_ready, busy, res_data);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    int bad;
    send(32'h3F800000, 2); send(32'h40000000, 0); send(32'h40400000, 3); send(32'h40800000, 1);
    checks++;
    if (core_x1 !== 32'h3F800000 || core_x2 !== 32'h40000000 || core_x3 !== 32'h40400000 || core_x4 !== 32'h40800000) begin
      errors++;
      $display("FAIL gaps_x got %h %h %h %h exp 3f800000 40000000 40400000 40800000", core_x1, core_x2, core_x3, core_x4);
    end
    cyc();
    pulse_done(32'h40800000);
    s0 = starts;
    bad = 0;
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    for (int i = 0; i < 10; i++) begin
      core_done = (i % 3 == 0);
      core_out  = 32'hDEAD0000 + i;
      cyc();
      if (res_valid !== 1'b1 || res_data !== 32'h40800000 || res_timeout !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    core_done = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0 (d=%h)", bad, res_data); end
    checks++;
    if (starts != s0) begin errors++; $display("FAIL hold_no_restart got %0d exp %0d", starts, s0); end
    take_result();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got rdy=%b v=%b exp 1 0", in_ready, res_valid);
    end
  endtask

  task automatic test_timeout();
    int early;
    send4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    cyc();
    early = 0;
    for (int k = 1; k < 16; k++) begin
      cyc();
      if (res_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL timeout_early got %0d early cycles exp 0", early); end
    cyc();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0 || res_timeout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result got v=%b d=%h to=%b busy=%b exp 1 0 1 1", res_valid, res_data, res_timeout, busy);
    end
    pulse_done(32'h12345678);
    checks++;
    if (res_data !== 32'h0 || res_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_late_done got d=%h to=%b exp 0 1", res_data, res_timeout);
    end
    take_result();
    checks++;
    if (res_timeout !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release got to=%b v=%b exp 0 0", res_timeout, res_valid);
    end
  endtask

  task automatic test_sanitize();
    send4(32'h3F800000, 32'hBF800000, 32'h7FC00000, 32'h40000000);
    checks++;
    if (core_x1 !== 32'h3F800000 || core_x2 !== 32'h0 || core_x3 !== 32'h0 || core_x4 !== 32'h40000000) begin
      errors++;
      $display("FAIL san_x got %h %h %h %h exp 3f800000 0 0 40000000", core_x1, core_x2, core_x3, core_x4);
    end
    cyc();
    pulse_done(32'h40000000);
    checks++;
    if (res_sanitized !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL san_flag got san=%b v=%b exp 1 1", res_sanitized, res_valid);
    end
    take_result();
    checks++;
    if (res_sanitized !== 1'b0) begin errors++; $display("FAIL san_flag_clear got %b exp 0", res_sanitized); end
    send4(32'h80000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    checks++;
    if (core_x1 !== 32'h0 || core_x2 !== 32'h3F000000) begin
      errors++;
      $display("FAIL san_negzero_x got x1=%h x2=%h exp 0 3f000000", core_x1, core_x2);
    end
    cyc();
    pulse_done(32'h3F000000);
    checks++;
    if (res_sanitized !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL san_negzero_flag got san=%b v=%b exp 0 1", res_sanitized, res_valid);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    send4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    repeat (2) cyc();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, core_start, res_valid, res_timeout, res_sanitized, busy} !== 6'b0 ||
        core_x1 !== 32'h0 || core_x4 !== 32'h0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async got rdy=%b busy=%b x1=%h x4=%h rd=%h exp all 0", in_ready, busy, core_x1, core_x4, res_data);
    end
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", in_ready); end
    send(32'h41200000, 0);
    checks++;
    if (core_x1 !== 32'h41200000 || core_x2 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_slot got x1=%h x2=%h exp 41200000 0", core_x1, core_x2);
    end
    send(32'h3F800000, 0); send(32'h3F800000, 0); send(32'h3F800000, 0);
    cyc();
    pulse_done(32'h41200000);
    take_result();
  endtask

  task automatic test_done_at_timeout();
    send4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h41200000);
    cyc();
    repeat (15) cyc();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL tie_early got %b exp 0", res_valid); end
    pulse_done(32'h41200000);
    checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_data !== 32'h41200000) begin
      errors++;
      $display("FAIL tie_done_wins got v=%b to=%b d=%h exp 1 0 41200000", res_valid, res_timeout, res_data);
    end
    take_result();
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_sanitize();
    test_reset_mid();
    test_done_at_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
